// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared load/store size codes, responder FSM encoding and the
//            XLEN-to-width mapping used by the MEM-stage data path.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef XLEN_64b
`define XLEN_64b 64
`endif
`ifndef XLEN_32b
`define XLEN_32b 32
`endif

package pipeline_pkg;

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_d  = 3'b011;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;
    localparam logic [2:0] c_f3_wu = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_e;

    function automatic int xlen_width(input int xlen);
        return (xlen == `XLEN_32b) ? 32 : 64;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Combinational byte-lane steering: store mask/shift and load
//            lane extract with sign or zero extension.
// Revision : 1.0 - initial release
// ============================================================================

module dmem_lane_align
    import pipeline_pkg::*;
#(
    parameter int W      = 64,
    parameter int LANE_W = $clog2(W / 8)
) (
    input  logic [2:0]        i_f3,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [W-1:0]      i_wdata,
    input  logic [W-1:0]      i_rword,
    output logic [W/8-1:0]    o_wmask,
    output logic [W-1:0]      o_wdata,
    output logic [W-1:0]      o_rdata
);

    localparam int NB = W / 8;

    logic [7:0]        w_size_mask;
    logic [LANE_W+2:0] w_bit_off;
    logic [W-1:0]      w_rshift;

    assign w_bit_off = {i_lane, 3'b000};
    assign o_wdata   = i_wdata << w_bit_off;
    assign w_rshift  = i_rword >> w_bit_off;

    always_comb begin
        case (i_f3[1:0])
            2'd0:    w_size_mask = 8'h01;
            2'd1:    w_size_mask = 8'h03;
            2'd2:    w_size_mask = 8'h0f;
            default: w_size_mask = 8'hff;
        endcase
        o_wmask = NB'(w_size_mask) << i_lane;
    end

    // Size casts of signed operands replicate the sign bit.
    always_comb begin
        case (i_f3)
            c_f3_b:  o_rdata = W'($signed(w_rshift[7:0]));
            c_f3_h:  o_rdata = W'($signed(w_rshift[15:0]));
            c_f3_w:  o_rdata = W'($signed(w_rshift[31:0]));
            c_f3_d:  o_rdata = w_rshift;
            c_f3_bu: o_rdata = W'(w_rshift[7:0]);
            c_f3_hu: o_rdata = W'(w_rshift[15:0]);
            c_f3_wu: o_rdata = W'(w_rshift[31:0]);
            default: o_rdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Wait-stated data-memory responder for the MEM-stage load/store
//            port. Optional macro DMEM_MISALIGN_TRAP_EN enables alignment traps.
// Revision : 1.0 - initial release
// ============================================================================

module dmem_responder
    import pipeline_pkg::*;
#(
    parameter int XLEN        = `XLEN_64b,
    parameter int DEPTH_WORDS = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_clk_en,
    input  logic                        i_req,
    input  logic                        i_we,
    input  logic [2:0]                  i_f3,
    input  logic [xlen_width(XLEN)-1:0] i_addr,
    input  logic [xlen_width(XLEN)-1:0] i_wdata,
    output logic                        o_ack,
    output logic [xlen_width(XLEN)-1:0] o_rdata,
    output logic                        o_stall,
    output logic                        o_misaligned
);

    localparam int W      = xlen_width(XLEN);
    localparam int NB     = W / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         we_q, we_d;
    logic [2:0]   f3_q, f3_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic         ack_q, ack_d;
    logic [W-1:0] rdata_q, rdata_d;
    logic         mis_q, mis_d;

    logic [W-1:0] mem [DEPTH_WORDS];

    logic              w_use_in;
    logic              w_a_we;
    logic [2:0]        w_a_f3;
    logic [W-1:0]      w_a_addr;
    logic [W-1:0]      w_a_wdata;
    logic [LANE_W-1:0] w_lo_mask;
    logic [LANE_W-1:0] w_lane_raw;
    logic [LANE_W-1:0] w_lane;
    logic [IDX_W-1:0]  w_index;
    logic              w_f3_bad;
    logic              w_fault;
    logic              w_access_ok;
    logic [W-1:0]      w_rword;
    logic [NB-1:0]     w_wmask;
    logic [W-1:0]      w_wdata_sh;
    logic [W-1:0]      w_rdata_ext;
    logic              w_commit;
    logic              w_unused_addr;

    // In IDLE the live request is decoded so a zero-wait access can respond at once.
    assign w_use_in  = (state_q == S_IDLE);
    assign w_a_we    = w_use_in ? i_we    : we_q;
    assign w_a_f3    = w_use_in ? i_f3    : f3_q;
    assign w_a_addr  = w_use_in ? i_addr  : addr_q;
    assign w_a_wdata = w_use_in ? i_wdata : wdata_q;

    always_comb begin
        case (w_a_f3[1:0])
            2'd0:    w_lo_mask = LANE_W'(0);
            2'd1:    w_lo_mask = LANE_W'(1);
            2'd2:    w_lo_mask = LANE_W'(3);
            default: w_lo_mask = LANE_W'(7);
        endcase
        w_lane_raw = w_a_addr[LANE_W-1:0];
        w_f3_bad   = (w_a_f3 == 3'b111) || ((W == 32) && (w_a_f3 == c_f3_d));
`ifdef DMEM_MISALIGN_TRAP_EN
        w_fault    = !w_f3_bad && ((w_lane_raw & w_lo_mask) != '0);
        w_lane     = w_lane_raw;
`else
        w_fault    = 1'b0;
        w_lane     = w_lane_raw & ~w_lo_mask;
`endif
        w_access_ok = !w_f3_bad && !w_fault;
    end

    assign w_index       = w_a_addr[IDX_W+LANE_W-1:LANE_W];
    assign w_unused_addr = ^w_a_addr[W-1:IDX_W+LANE_W];
    assign w_rword       = mem[w_index];

    dmem_lane_align #(
        .W      (W),
        .LANE_W (LANE_W)
    ) u_align (
        .i_f3    (w_a_f3),
        .i_lane  (w_lane),
        .i_wdata (w_a_wdata),
        .i_rword (w_rword),
        .o_wmask (w_wmask),
        .o_wdata (w_wdata_sh),
        .o_rdata (w_rdata_ext)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = ack_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        w_commit = 1'b0;
        if (i_clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (i_req) begin
                        we_d    = i_we;
                        f3_d    = i_f3;
                        addr_d  = i_addr;
                        wdata_d = i_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_d = S_RESP;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = c_wait_load;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    w_commit = we_q && w_access_ok;
                end
            endcase
            if (state_q != S_RESP && state_d == S_RESP) begin
                ack_d   = 1'b1;
                rdata_d = (w_a_we || !w_access_ok) ? '0 : w_rdata_ext;
                mis_d   = w_fault;
            end else if (state_q == S_RESP) begin
                ack_d = 1'b0;
                mis_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Array has no reset; a reset on the commit edge drops the pending store.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_commit) begin
            for (int b = 0; b < NB; b++) begin
                if (w_wmask[b]) begin
                    mem[w_index][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    assign o_ack        = ack_q;
    assign o_rdata      = rdata_q;
    assign o_misaligned = mis_q;
    assign o_stall      = i_req & ~ack_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder (XLEN 64, two wait states)
//            against a byte-addressed behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_dmem_responder;

    localparam int WAITC = 2;
    localparam int MEMB  = 512 * 8;

    logic        clk = 1'b0;
    logic        rst, clk_en, req, we;
    logic [2:0]  f3;
    logic [63:0] addr, wdata;
    logic        ack, stall, mis;
    logic [63:0] rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    int          edge_cnt = 0;
    bit          chk_en = 0;
    bit          pending = 0;
    int          due = 0;
    logic [63:0] exp_rdata = '0;
    logic        exp_mis = 1'b0;
    logic [7:0]  mb [MEMB];

    dmem_responder #(
        .XLEN        (`XLEN_64b),
        .DEPTH_WORDS (512),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clk_en     (clk_en),
        .i_req        (req),
        .i_we         (we),
        .i_f3         (f3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_ack        (ack),
        .o_rdata      (rdata),
        .o_stall      (stall),
        .o_misaligned (mis)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [2:0] f, input logic [63:0] a,
                                               output logic m);
        int          sz;
        int          base;
        logic [63:0] v;
        m = 1'b0;
        if (f == 3'b111) return 64'd0;
        sz   = 1 << f[1:0];
        base = int'(a[11:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((base % sz) != 0) begin
            m = 1'b1;
            return 64'd0;
        end
`else
        base = base - (base % sz);
`endif
        v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[(base + i) % MEMB];
        if (!f[2] && sz < 8 && v[8*sz-1]) begin
            for (int i = 8 * sz; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f, input logic [63:0] a, input logic [63:0] d);
        int sz;
        int base;
        if (f == 3'b111) return;
        sz   = 1 << f[1:0];
        base = int'(a[11:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((base % sz) != 0) return;
`else
        base = base - (base % sz);
`endif
        for (int i = 0; i < sz; i++) mb[(base + i) % MEMB] = d[8*i +: 8];
    endtask

    // Cycle-by-cycle comparison of handshake and response against the model.
    always @(negedge clk) begin
        logic exp_ack;
        if (chk_en) begin
            exp_ack = pending && (edge_cnt == due);
            check("ack", {63'd0, ack}, {63'd0, exp_ack});
            check("stall", {63'd0, stall}, {63'd0, req & ~exp_ack});
            if (exp_ack) begin
                check("rdata", rdata, exp_rdata);
                check("misaligned", {63'd0, mis}, {63'd0, exp_mis});
            end
        end
    end

    task automatic access(input logic w, input logic [2:0] f, input logic [63:0] a,
                          input logic [63:0] d, input int dis,
                          output logic [63:0] got, output logic got_mis, output int lat);
        int          n;
        logic        m;
        logic [63:0] e;
        bit          seen;
        @(posedge clk);
        #1;
        e = model_load(f, a, m);
        if (w) e = 64'd0;
        exp_rdata = e;
        exp_mis   = m;
        n         = edge_cnt;
        due       = n + WAITC + 1 + dis;
        pending   = 1'b1;
        req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
        if (dis > 0) begin
            @(posedge clk);
            #1 clk_en = 1'b0;
            repeat (dis) @(posedge clk);
            #1 clk_en = 1'b1;
        end
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        if (!seen) check("ack_timeout", 64'd0, 64'd1);
        got     = rdata;
        got_mis = mis;
        lat     = edge_cnt - n;
        @(posedge clk);
        #1;
        req     = 1'b0;
        pending = 1'b0;
        if (w && seen) model_store(f, a, d);
    endtask

    initial begin
        logic [63:0] got;
        logic        gm;
        int          lat;

        rst = 1'b1; clk_en = 1'b0; req = 1'b0; we = 1'b0;
        f3 = 3'd0; addr = '0; wdata = '0;
        for (int i = 0; i < MEMB; i++) mb[i] = 8'h00;

        // Reset must win even with the clock enable low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {63'd0, ack}, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_mis", {63'd0, mis}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        clk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        access(1'b1, 3'b011, 64'h10, 64'h1122334455667788, 0, got, gm, lat);
        check("sd_latency", 64'(lat), 64'd3);
        check("sd_rdata", got, 64'd0);
        access(1'b0, 3'b011, 64'h10, 64'd0, 0, got, gm, lat);
        check("ld_latency", 64'(lat), 64'd3);
        check("ld_10", got, 64'h1122334455667788);
        access(1'b0, 3'b000, 64'h10, 64'd0, 0, got, gm, lat);
        check("lb_10", got, 64'hFFFFFFFFFFFFFF88);
        access(1'b0, 3'b100, 64'h10, 64'd0, 0, got, gm, lat);
        check("lbu_10", got, 64'h0000000000000088);
        access(1'b0, 3'b000, 64'h17, 64'd0, 0, got, gm, lat);
        check("lb_17", got, 64'h0000000000000011);

        access(1'b0, 3'b010, 64'h11, 64'd0, 0, got, gm, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lw_11_rdata", got, 64'd0);
        check("lw_11_mis", {63'd0, gm}, 64'd1);
`else
        check("lw_11_rdata", got, 64'h0000000055667788);
        check("lw_11_mis", {63'd0, gm}, 64'd0);
`endif

        access(1'b1, 3'b001, 64'h12, 64'h000000000000ABCD, 0, got, gm, lat);
        access(1'b0, 3'b011, 64'h10, 64'd0, 0, got, gm, lat);
        check("ld_after_sh", got, 64'h11223344ABCD7788);
        access(1'b0, 3'b001, 64'h12, 64'd0, 0, got, gm, lat);
        check("lh_12", got, 64'hFFFFFFFFFFFFABCD);

        // Reset pulsed while an SD of zero sits in WAIT: the store must vanish.
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; f3 = 3'b011; addr = 64'h10; wdata = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        access(1'b0, 3'b011, 64'h10, 64'd0, 0, got, gm, lat);
        check("ld_after_rst", got, 64'h11223344ABCD7788);

        access(1'b0, 3'b011, 64'h10, 64'd0, 5, got, gm, lat);
        check("clk_en_latency", 64'(lat), 64'd8);
        check("clk_en_rdata", got, 64'h11223344ABCD7788);

        access(1'b0, 3'b111, 64'h10, 64'd0, 0, got, gm, lat);
        check("f3_111", got, 64'd0);
        access(1'b0, 3'b011, 64'h1010, 64'd0, 0, got, gm, lat);
        check("ld_wrap", got, 64'h11223344ABCD7788);

        access(1'b1, 3'b001, 64'h13, 64'h0000000000005555, 0, got, gm, lat);
        access(1'b0, 3'b011, 64'h10, 64'd0, 0, got, gm, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("ld_after_bad_sh", got, 64'h11223344ABCD7788);
`else
        check("ld_after_bad_sh", got, 64'h1122334455557788);
`endif
        access(1'b1, 3'b000, 64'hFFF, 64'h00000000000000A5, 0, got, gm, lat);
        access(1'b0, 3'b100, 64'hFFF, 64'd0, 0, got, gm, lat);
        check("lbu_top", got, 64'h00000000000000A5);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far end of the pipeline's MEM-stage load/store interface. It accepts one request at a time from the core, inserts a configurable number of wait states, then reads or writes a dword-organised array with RISC-V size and sign handling taken from `f3`. It returns read data with a one-cycle acknowledge. Its `o_stall` output feeds the hazard unit, which freezes the pipeline until the access completes.

## Interface
- `XLEN`, default `` `XLEN_64b ``: data width W is 64 for `` `XLEN_64b `` and 32 for `` `XLEN_32b ``.
- `DEPTH_WORDS`, default 512: number of W-bit array entries; must be a power of 2.
- `WAIT_CYCLES`, default 2: wait states per access, range 0..15.

- `i_clk` in, 1 bit: the single clock; all state changes on its rising edge.
- `i_rst` in, 1 bit: synchronous, active-high reset.
- `i_clk_en` in, 1 bit: global step enable; all state is frozen while it is low.
- `i_req` in, 1 bit: request valid; held stable by the core until `o_ack`.
- `i_we` in, 1 bit: 1 selects store, 0 selects load.
- `i_f3` in, 3 bits: size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- `i_addr` in, W bits: byte address.
- `i_wdata` in, W bits: store data, taken from the low bytes.
- `o_ack` out, 1 bit: access complete; high exactly one enabled cycle.
- `o_rdata` out, W bits: load result, sign- or zero-extended; valid while `o_ack` is high.
- `o_stall` out, 1 bit: combinational `i_req & ~o_ack`.
- `o_misaligned` out, 1 bit: alignment fault, valid with `o_ack`.

## Operation
- FSM states and transitions:
  - IDLE: if `i_req` is high, latch `we`, `f3`, `addr` and `wdata`. Go to RESP if `WAIT_CYCLES`==0, otherwise load the counter with `WAIT_CYCLES-1` and go to WAIT.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP: `o_ack`=1, then always return to IDLE.
- `o_rdata` is registered and loaded on the edge that enters RESP.
  - Source is `mem[index]`, with the lane extracted and then extended per `f3`.
  - When `WAIT_CYCLES`==0, the incoming fields are used directly instead of the latched copy.
- Store commits on the edge leaving RESP.
  - Only the addressed byte lanes are written (byte-write mask).
  - `o_rdata` for a store is 0.
- Address decode:
  - XLEN 64: index = `addr[log2(DEPTH)+2:3]`, lane = `addr[2:0]`.
  - XLEN 32: index = `addr[log2(DEPTH)+1:2]`, lane = `addr[1:0]`.
  - Address bits above the index are ignored, so the array wraps.
- `f3` of 011 under XLEN 32, or `f3` of 111 under either XLEN: no array access, `o_rdata`=0, and `o_ack` is still given.
- Little-endian byte order.
- `i_req` seen in RESP or WAIT is not re-sampled; the next request is accepted in IDLE only.

## Timing
- Reset values: state IDLE, counter 0, `o_ack` 0, `o_rdata` 0, `o_misaligned` 0. The array is not reset.
- Latency: a request sampled in IDLE at cycle 0 gives `o_ack` in cycle `WAIT_CYCLES+1`.
- Throughput: back-to-back requests complete one per `WAIT_CYCLES+2` cycles.
- `i_clk_en` low:
  - FSM, counter, `o_rdata` and the write commit all hold.
  - `o_ack` stays high if in RESP.
  - Total latency stretches by exactly the number of disabled cycles.
- Reset mid-access, in WAIT or RESP:
  - The FSM returns to IDLE and the pending store is discarded.
  - No `o_ack` is produced.
- `i_rst` and `i_clk_en` low together: reset wins.

## Configuration
- Macro `DMEM_MISALIGN_TRAP_EN`, defined:
  - An access whose address is not aligned to its size performs no write and returns `o_rdata`=0.
  - It raises `o_misaligned`=1 together with `o_ack`, for that one cycle only.
- Undefined:
  - The low address bits are masked down to the size alignment and the access proceeds normally.
  - `o_misaligned` is tied to 0; the port is still present.

## Structure
- Shared `pipeline_pkg` holds:
  - the `f3` size/sign localparams;
  - the FSM state encoding (IDLE/WAIT/RESP);
  - the function mapping XLEN to W.
- Sub-module `dmem_lane_align` (combinational) implements:
  - byte write-mask and write-data shift from `f3` and lane;
  - read lane extract and sign/zero extend.
- The top level holds the FSM, counter, latches, array and alignment check.

## Test plan
All cases use XLEN 64 and `WAIT_CYCLES`=2.
- SD 0x1122334455667788 to 0x10, then LD 0x10: each `o_ack` comes 3 cycles after its request, and the load returns 0x1122334455667788.
- After that store, LB 0x10 returns 0xFFFFFFFFFFFFFF88, LBU 0x10 returns 0x0000000000000088, and LB 0x17 returns 0x0000000000000011.
- SH 0xABCD to 0x12, then LD 0x10: returns 0x11223344ABCD7788; no other bytes change.
- LW 0x11:
  - With the macro defined: `o_misaligned`=1, `o_rdata`=0, memory unchanged.
  - Without it: the access goes to 0x10 and returns 0x0000000055667788.
- `i_rst` pulsed during WAIT of an SD of 0 to 0x10: no `o_ack`; a following LD 0x10 returns the old 0x11223344ABCD7788.
- `i_clk_en` held low for 5 cycles during WAIT: `o_ack` arrives exactly 5 cycles later than nominal, and `o_stall` stays high throughout.
